onchip_mem_arbiter: RTL
=======================

Name: onchip_mem_arbiter

Overview:
- Two-master Avalon-MM arbiter that shares the single-port on-chip RAM (32-bit, 5120 words, unregistered read output, 1-cycle read latency) between the Nios II data master and a DMA/peripheral master.
- Issues at most one access per cycle to the RAM port.
- Uses sticky-then-round-robin grant with a bounded hold count.
- Routes read data back to the owning master with a registered readdatavalid.

Parameters:
- ADDR_W, 13, word address width of masters and RAM port
- DEPTH, 5120, number of implemented words; addresses >= DEPTH are out of range
- MAX_HOLD, 4, maximum consecutive grants to one master while the other is requesting (1..15)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_address  in  ADDR_W  master 0 word address
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_byteenable  in  4  master 0 byte lanes
- m0_writedata  in  32  master 0 write data
- m0_waitrequest  out  1  high = master 0 request not accepted this cycle
- m0_readdata  out  32  master 0 read data
- m0_readdatavalid  out  1  master 0 read data valid
- m1_*  same set of ports for master 1
- mem_address  out  ADDR_W  RAM address
- mem_chipselect  out  1  RAM select
- mem_write  out  1  RAM write
- mem_byteenable  out  4  RAM byte lanes
- mem_writedata  out  32  RAM write data
- mem_clken  out  1  RAM clock enable
- mem_readdata  in  32  RAM read data, valid one cycle after the read address

Behaviour:
- Clocking and reset: one clock domain (clk); reset_n is asynchronous and active-low.
- Request definition: reqN = mN_read | mN_write. Read and write asserted together is illegal; the access is treated as a write.
- Grant (combinational, one cycle):
  - If only one master requests, that master wins.
  - If both request and hold_cnt < MAX_HOLD, last_owner wins (sticky).
  - Otherwise the master other than last_owner wins.
- Handshake:
  - mN_waitrequest = reqN & ~grantN.
  - mN_waitrequest = 1 when reqN = 0 is also allowed; the implementation drives ~grantN.
  - The accept cycle is the cycle in which the request is high and waitrequest is low.
- RAM drive:
  - mem_* mirrors the granted master's signals.
  - mem_chipselect = grant_any & in_range, where in_range = (address < DEPTH).
  - mem_write = granted write & in_range.
  - mem_clken = 1 whenever reset_n = 1.
  - Outputs are all-zero (except mem_clken) when there is no grant.
- Registered state, cleared on reset:
  - last_owner = 0
  - hold_cnt = 0 (4 bits)
  - rd_pend = 0
  - rd_owner = 0
  - rd_oor = 0
- Per-accept updates:
  - Same owner as last_owner and the other master was requesting: hold_cnt = hold_cnt + 1, saturating at MAX_HOLD.
  - Switch of owner, or other master idle: hold_cnt = 1 on a switch, unchanged otherwise. last_owner = winner.
  - No accept this cycle: hold_cnt and last_owner hold.
- Read return:
  - An accepted read sets rd_pend = 1, rd_owner = winner and rd_oor = ~in_range for the next cycle; otherwise rd_pend = 0.
  - mN_readdatavalid = rd_pend & (rd_owner == N).
  - mN_readdata = rd_oor ? 0 : mem_readdata when valid, 0 otherwise.
  - Latency: accept cycle T, data valid at T+1. Back-to-back reads sustain 1 word per cycle.
- Out-of-range access:
  - Writes are accepted and discarded.
  - Reads are accepted and return 32'h0 with normal latency.
- Simultaneous events:
  - A write accepted in the cycle after a read does not disturb that read's return; the RAM output for cycle T+1 belongs to the T access.
  - A read by one master followed by a write by the other is serialized by the grant.
- Reset mid-operation: asserting reset_n low clears rd_pend immediately, so no readdatavalid is issued for a read in flight. Grant restarts with master 0 sticky.
- Reset values of outputs:
  - mN_readdatavalid = 0 and mN_readdata = 0.
  - mem_clken = 0 while reset_n = 0.
  - waitrequest and mem_* follow the combinational rules.

Test Plan:
1. Single master: m0 reads addr 0x010 after m0 writes 0xDEADBEEF there -> m0_waitrequest = 0 on both accepts; m0_readdatavalid one cycle after the read accept with m0_readdata = 0xDEADBEEF; m1 sees no readdatavalid.
2. Contention with MAX_HOLD = 4: m0 and m1 both hold continuous reads from reset -> grants follow m0 ×4, m1 ×4, m0 ×4, …; each readdatavalid goes to the correct master one cycle after its accept; no cycle has both grants.
3. Byte enables: write 0x11223344 with be 4'b0101 over existing 0xFFFFFFFF -> readback 0xFF22FF44.
4. Out-of-range: m1 writes 0xA5A5A5A5 to 5120, then reads 5120 -> write accepted with mem_chipselect = 0; read returns 0x00000000 with readdatavalid at T+1. Word 0 is unchanged.
5. Reset mid-read: reset_n driven low in the cycle after a read accept -> no readdatavalid asserted. After release, the first contended grant goes to m0.
6. Interleave: m0 reads 0x020 in cycle T while m1 is waiting; m1 writes 0x020 in T+1 -> m0 receives the old value at T+1; a subsequent m0 read returns the m1 data.

Source files
------------

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM master-side bus bundle shared by both arbiter requestors.
// The arbiter takes the slave view; masters or benches take the master view.
interface onchip_mem_arbiter_if #(
   parameter int ADDR_W = 13
);
   logic [ADDR_W-1:0] address;
   logic              read;
   logic              write;
   logic [3:0]        byteenable;
   logic [31:0]       writedata;
   logic              waitrequest;
   logic [31:0]       readdata;
   logic              readdatavalid;

   modport master (
      output address, read, write, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter for a single-port on-chip RAM with sticky-then-round-robin
// grant, bounded hold count and registered read-return routing.
module onchip_mem_arbiter #(
   parameter int ADDR_W   = 13,
   parameter int DEPTH    = 5120,
   parameter int MAX_HOLD = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   onchip_mem_arbiter_if.slave m0,
   onchip_mem_arbiter_if.slave m1,
   output logic [ADDR_W-1:0]   mem_address,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [3:0]          mem_byteenable,
   output logic [31:0]         mem_writedata,
   output logic                mem_clken,
   input  logic [31:0]         mem_readdata
);

   localparam logic [ADDR_W:0] DEPTH_L    = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]      MAX_HOLD_L = 4'(MAX_HOLD);

   logic              req0_s, req1_s, grant_any_s, winner_s, other_req_s;
   logic [ADDR_W-1:0] sel_addr_s;
   logic              sel_wr_s, in_range_s;
   logic [3:0]        sel_be_s;
   logic [31:0]       sel_wdata_s;
   logic              last_owner_r, rd_pend_r, rd_owner_r, rd_oor_r;
   logic [3:0]        hold_cnt_r;

   function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
      if (cnt >= MAX_HOLD_L) begin
         return MAX_HOLD_L;
      end else begin
         return cnt + 4'd1;
      end
   endfunction

   assign req0_s    = m0.read | m0.write;
   assign req1_s    = m1.read | m1.write;
   assign mem_clken = reset_n;

   // Grant decision: a lone requestor wins, otherwise sticky until hold expires.
   always_comb begin
      grant_any_s = req0_s | req1_s;
      if (req0_s & ~req1_s) begin
         winner_s = 1'b0;
      end else if (req1_s & ~req0_s) begin
         winner_s = 1'b1;
      end else if (hold_cnt_r < MAX_HOLD_L) begin
         winner_s = last_owner_r;
      end else begin
         winner_s = ~last_owner_r;
      end
      other_req_s = winner_s ? req0_s : req1_s;
   end

   // Select the granted master's request fields; read+write counts as write.
   always_comb begin
      if (winner_s) begin
         sel_addr_s  = m1.address;
         sel_wr_s    = m1.write;
         sel_be_s    = m1.byteenable;
         sel_wdata_s = m1.writedata;
      end else begin
         sel_addr_s  = m0.address;
         sel_wr_s    = m0.write;
         sel_be_s    = m0.byteenable;
         sel_wdata_s = m0.writedata;
      end
      in_range_s = ({1'b0, sel_addr_s} < DEPTH_L);
   end

   // RAM port drive; out-of-range accesses are accepted but never reach the RAM.
   always_comb begin
      if (grant_any_s) begin
         mem_address    = sel_addr_s;
         mem_chipselect = in_range_s;
         mem_write      = sel_wr_s & in_range_s;
         mem_byteenable = sel_be_s;
         mem_writedata  = sel_wdata_s;
      end else begin
         mem_address    = {ADDR_W{1'b0}};
         mem_chipselect = 1'b0;
         mem_write      = 1'b0;
         mem_byteenable = 4'h0;
         mem_writedata  = 32'h0;
      end
   end

   // Handshake and read-return routing back to the owner of the pending read.
   always_comb begin
      m0.waitrequest   = ~(grant_any_s & ~winner_s);
      m1.waitrequest   = ~(grant_any_s & winner_s);
      m0.readdatavalid = rd_pend_r & ~rd_owner_r;
      m1.readdatavalid = rd_pend_r & rd_owner_r;
      if (rd_pend_r & ~rd_oor_r) begin
         m0.readdata = rd_owner_r ? 32'h0 : mem_readdata;
         m1.readdata = rd_owner_r ? mem_readdata : 32'h0;
      end else begin
         m0.readdata = 32'h0;
         m1.readdata = 32'h0;
      end
   end

   // Ownership/hold tracking and read-pending state, updated on every accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_owner_r <= 1'b0;
         hold_cnt_r   <= 4'd0;
         rd_pend_r    <= 1'b0;
         rd_owner_r   <= 1'b0;
         rd_oor_r     <= 1'b0;
      end else if (grant_any_s) begin
         last_owner_r <= winner_s;
         if (winner_s != last_owner_r) begin
            hold_cnt_r <= 4'd1;
         end else if (other_req_s) begin
            hold_cnt_r <= sat_inc(hold_cnt_r);
         end else begin
            hold_cnt_r <= hold_cnt_r;
         end
         rd_pend_r  <= ~sel_wr_s;
         rd_owner_r <= winner_s;
         rd_oor_r   <= ~in_range_s;
      end else begin
         rd_pend_r  <= 1'b0;
      end
   end

endmodule
